ps2_rx_fifo: RTL and testbench

PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

---
 rtl/ps2_rx_fifo.sv | 121 ++++++++++++
 tb/tb_ps2_rx_fifo.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host frame receiver feeding a first-word-fall-through frame FIFO.
// Define PS2_RX_GLITCH_FILTER_EN to add a FILTER_LEN-sample glitch filter on both PS/2 lines.
module ps2_rx_fifo #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH = 4,
  parameter int FILTER_LEN = 4
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          CLK_MOUSE_IN,
  input  logic                          DATA_MOUSE_IN,
  input  logic                          READ_ENABLE,
  input  logic                          BYTE_POP,
  output logic [7:0]                    BYTE_READ,
  output logic [1:0]                    BYTE_ERROR_CODE,
  output logic                          BYTE_READY,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
  output logic                          OVERFLOW,
  output logic                          TIMEOUT
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, PUSH} state_t;
  state_t state, state_nxt;
  logic [1:0] clk_sync, data_sync;
  logic clk_c, data_c, clk_prev, fall, busy, start, expire;
  logic [2:0] bit_cnt;
  logic [TW-1:0] to_cnt;
  logic [7:0] shift;
  logic par_err, stop_err;
  logic [9:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push_req, full, pop, push;
`ifdef PS2_RX_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN);
  logic [FW-1:0] clk_run, data_run;
  // A line's conditioned value follows the synchroniser only after FILTER_LEN differing samples in a row.
  always_ff @(posedge CLK)
    if (!RESET) begin
      clk_c <= 1'b1;
      data_c <= 1'b1;
      clk_run <= '0;
      data_run <= '0;
    end else begin
      clk_run <= (clk_sync[1] == clk_c || clk_run == FW'(FILTER_LEN - 1)) ? '0 : clk_run + 1'b1;
      data_run <= (data_sync[1] == data_c || data_run == FW'(FILTER_LEN - 1)) ? '0 : data_run + 1'b1;
      if (clk_sync[1] != clk_c && clk_run == FW'(FILTER_LEN - 1)) clk_c <= clk_sync[1];
      if (data_sync[1] != data_c && data_run == FW'(FILTER_LEN - 1)) data_c <= data_sync[1];
    end
`else
  assign clk_c = clk_sync[1];
  assign data_c = data_sync[1];
`endif
  assign fall = clk_prev & ~clk_c;
  assign busy = state == DATA || state == PARITY || state == STOP;
  assign start = state == IDLE && fall && READ_ENABLE && !data_c;
  assign expire = busy && !fall && to_cnt == TW'(TIMEOUT_CYCLES - 1);
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? DATA : IDLE;
      DATA:    state_nxt = expire ? IDLE : (fall && bit_cnt == 3'd7) ? PARITY : DATA;
      PARITY:  state_nxt = expire ? IDLE : fall ? STOP : PARITY;
      STOP:    state_nxt = expire ? IDLE : fall ? PUSH : STOP;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge CLK)
    if (!RESET) begin
      clk_sync <= 2'b11;
      data_sync <= 2'b11;
      clk_prev <= 1'b1;
      state <= IDLE;
      bit_cnt <= '0;
      to_cnt <= '0;
      shift <= '0;
      par_err <= 1'b0;
      stop_err <= 1'b0;
      TIMEOUT <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], CLK_MOUSE_IN};
      data_sync <= {data_sync[0], DATA_MOUSE_IN};
      clk_prev <= clk_c;
      state <= state_nxt;
      TIMEOUT <= expire;
      if (start) begin
        bit_cnt <= '0;
        to_cnt <= '0;
        par_err <= 1'b0;
        stop_err <= 1'b0;
      end
      if (busy) to_cnt <= fall ? '0 : to_cnt + 1'b1;
      if (fall && state == DATA) begin
        shift <= {data_c, shift[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (fall && state == PARITY) par_err <= data_c != ~^shift;
      if (fall && state == STOP) stop_err <= ~data_c;
    end
  // A pop frees the head slot in the same cycle, so a push into a full FIFO still lands.
  assign push_req = state == PUSH;
  assign full = FIFO_COUNT == (AW + 1)'(FIFO_DEPTH);
  assign pop = BYTE_POP && BYTE_READY;
  assign push = push_req && (!full || pop);
  assign BYTE_READY = FIFO_COUNT != '0;
  assign {BYTE_ERROR_CODE, BYTE_READ} = BYTE_READY ? mem[rd_ptr] : 10'd0;
  always_ff @(posedge CLK)
    if (push) mem[wr_ptr] <= {stop_err, par_err, shift};
  always_ff @(posedge CLK)
    if (!RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      FIFO_COUNT <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      FIFO_COUNT <= FIFO_COUNT + (AW + 1)'(push) - (AW + 1)'(pop);
      OVERFLOW <= OVERFLOW | (push_req && full && !pop);
    end
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: directed frames against ps2_rx_fifo with a time-scaled PS/2 bit period.
// TIMEOUT_CYCLES is shrunk to keep the run short; latencies are expressed in terms of T and H.
module tb_ps2_rx_fifo;
  localparam int T = 1000;
  localparam int H = 20;
  logic clk = 1'b0, rst_n = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1, rd_en = 1'b0, pop = 1'b0;
  logic [7:0] byte_read;
  logic [1:0] err_code;
  logic ready, ovf, tmo;
  logic [2:0] count;
  int vectors = 0, miscompares = 0;
  int pulses, first;
  always #10 clk = ~clk;
  ps2_rx_fifo #(.TIMEOUT_CYCLES(T), .FIFO_DEPTH(4), .FILTER_LEN(4)) dut (
    .CLK(clk), .RESET(rst_n), .CLK_MOUSE_IN(ps2_clk), .DATA_MOUSE_IN(ps2_data),
    .READ_ENABLE(rd_en), .BYTE_POP(pop), .BYTE_READ(byte_read), .BYTE_ERROR_CODE(err_code),
    .BYTE_READY(ready), .FIFO_COUNT(count), .OVERFLOW(ovf), .TIMEOUT(tmo)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send_bit(input logic b, input logic pop_at_push = 1'b0);
    ps2_data = b;
    cycles(H);
    ps2_clk = 1'b0;
    if (pop_at_push) begin
      cycles(3);
      pop = 1'b1;
      cycles(1);
      pop = 1'b0;
      cycles(H - 4);
    end else cycles(H);
    ps2_clk = 1'b1;
  endtask
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input logic pop_at_push = 1'b0);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stp, pop_at_push);
    ps2_data = 1'b1;
    cycles(H);
  endtask
  task automatic pop_expect(input string tag, input logic [7:0] d);
    check(tag, byte_read, d);
    pop = 1'b1;
    cycles(1);
    pop = 1'b0;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(2);
  endtask
  task automatic check_zero(input string tag);
    check(tag, {byte_read, err_code, ready, count, ovf, tmo}, 0);
  endtask
  task automatic watch_timeout(input int n, output int np, output int at);
    np = 0;
    at = -1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tmo) begin
        np++;
        if (at < 0) at = i;
      end
    end
  endtask
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    cycles(3);
    check_zero("reset_outputs");
    rst_n = 1'b1;
    rd_en = 1'b1;
    cycles(4);
    send_frame(8'hA5, 1'b1, 1'b1);
    check("a5_data", byte_read, 8'hA5);
    check("a5_err", err_code, 2'b00);
    check("a5_count", count, 1);
    check("a5_ready", ready, 1);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    check("3c_pushpop_count", count, 1);
    check("3c_data", byte_read, 8'h3C);
    check("3c_err", err_code, 2'b11);
    pop_expect("3c_pop", 8'h3C);
    check("empty_count", count, 0);
    check("empty_zero_outputs", {byte_read, err_code, ready}, 0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    watch_timeout(T + 50, pulses, first);
    check("tmo_pulses", pulses, 1);
    check("tmo_latency", first, T + 2 - H);
    check("tmo_count", count, 0);
    ps2_data = 1'b0;
    cycles(10);
    ps2_clk = 1'b0;
    cycles(1);
    ps2_clk = 1'b1;
    watch_timeout(T + 50, pulses, first);
`ifdef PS2_RX_GLITCH_FILTER_EN
    check("glitch_no_start", pulses, 0);
`else
    check("glitch_starts_frame", pulses, 1);
`endif
    ps2_data = 1'b1;
    cycles(10);
    do_reset();
    for (int i = 1; i <= 5; i++) send_frame(8'(i), ~^(8'(i)), 1'b1);
    check("ovf_count", count, 4);
    check("ovf_flag", ovf, 1);
    for (int i = 1; i <= 4; i++) pop_expect($sformatf("ovf_pop%0d", i), 8'(i));
    check("ovf_drained", count, 0);
    check("ovf_sticky", ovf, 1);
    do_reset();
    check("ovf_reset", ovf, 0);
    for (int i = 16; i <= 19; i++) send_frame(8'(i), ~^(8'(i)), 1'b1);
    check("full_count", count, 4);
    send_frame(8'h14, ~^8'h14, 1'b1, 1'b1);
    check("full_pushpop_count", count, 4);
    check("full_pushpop_ovf", ovf, 0);
    for (int i = 17; i <= 20; i++) pop_expect($sformatf("full_pop%0d", i), 8'(i));
    send_frame(8'h21, ~^8'h21, 1'b1);
    send_frame(8'h22, ~^8'h22, 1'b1);
    check("rst_queued", count, 2);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rst_n = 1'b0;
    cycles(1);
    check_zero("rst_midframe_outputs");
    rst_n = 1'b1;
    watch_timeout(T + 50, pulses, first);
    check("rst_no_timeout", pulses, 0);
    send_frame(8'h7E, ~^8'h7E, 1'b1);
    check("7e_data", byte_read, 8'h7E);
    check("7e_err", err_code, 2'b00);
    check("7e_count", count, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
